fsm_chain: RTL

- Parametrised linear-chain state machine; successor to the fixed 7-state advance-on-input FSM used in the regression designs.
- Generalised in state count, with configurable wrap-around, a backward step, a synchronous clear, a clock enable, and a minimum-dwell qualifier on every transition.
- Sits as a control sequencer; exposes both a binary state index and a one-hot state vector.

---
 rtl/fsm_chain.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fsm_chain.sv
// Parametrised linear-chain sequencer with wrap, back-step, clear,
// clock enable and a minimum-dwell qualifier on every step.
module fsm_chain #(
  parameter int NUM_STATES = 7,
  parameter bit WRAP       = 1'b1,
  parameter int MIN_DWELL  = 0,
  parameter int DWELL_W    = 4,
  localparam int SW = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  back,
  input  logic [NUM_STATES-1:0] adv,
  output logic [SW-1:0]         y,
  output logic [NUM_STATES-1:0] onehot,
  output logic                  wrapped,
  output logic [DWELL_W-1:0]    dwell
);

  localparam int ADW = 2 ** SW;
  localparam logic [SW-1:0] LAST = SW'(NUM_STATES - 1);
  localparam logic [DWELL_W-1:0] DMAX = '1;
  localparam logic [DWELL_W-1:0] MIN_D = DWELL_W'(MIN_DWELL);

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_CLR,
    ACT_FREEZE,
    ACT_BACK,
    ACT_FWD,
    ACT_WRAP
  } act_e;

  logic [SW-1:0]         y_q, y_d;
  logic [NUM_STATES-1:0] onehot_q, onehot_d;
  logic                  wrapped_q, wrapped_d;
  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  logic [DWELL_W-1:0]    dwell_inc;
  logic [ADW-1:0]        adv_x;
  logic                  ok;
  logic                  illegal;
  logic                  at_last;
  act_e                  act;

  // widen adv so any y_q value indexes a defined bit
  assign adv_x = ADW'(adv);
  assign at_last = (y_q == LAST);
  assign dwell_inc = (dwell_q == DMAX) ? dwell_q : dwell_q + 1'b1;

  if (MIN_DWELL == 0) begin : g_no_dwell
    assign ok = 1'b1;
  end else begin : g_dwell
    assign ok = (dwell_q >= MIN_D);
  end

  if (ADW == NUM_STATES) begin : g_full
    assign illegal = 1'b0;
  end else begin : g_sparse
    assign illegal = (y_q > LAST);
  end

  always_comb begin
    act = ACT_HOLD;
    if (clr || (en && illegal)) begin
      act = ACT_CLR;
    end else if (!en) begin
      act = ACT_FREEZE;
    end else if (back) begin
      if ((y_q != '0) && ok) act = ACT_BACK;
    end else if (adv_x[y_q] && ok) begin
      if (!at_last)  act = ACT_FWD;
      else if (WRAP) act = ACT_WRAP;
    end
  end

  always_comb begin
    y_d       = y_q;
    dwell_d   = dwell_q;
    wrapped_d = 1'b0;
    unique case (act)
      ACT_CLR: begin
        y_d     = '0;
        dwell_d = '0;
      end
      ACT_FREEZE: ;
      ACT_BACK: begin
        y_d     = y_q - SW'(1);
        dwell_d = '0;
      end
      ACT_FWD: begin
        y_d     = y_q + SW'(1);
        dwell_d = '0;
      end
      ACT_WRAP: begin
        y_d       = '0;
        dwell_d   = '0;
        wrapped_d = 1'b1;
      end
      default: dwell_d = dwell_inc;
    endcase
    onehot_d = NUM_STATES'(1) << y_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      y_q       <= '0;
      onehot_q  <= NUM_STATES'(1);
      wrapped_q <= 1'b0;
      dwell_q   <= '0;
    end else begin
      y_q       <= y_d;
      onehot_q  <= onehot_d;
      wrapped_q <= wrapped_d;
      dwell_q   <= dwell_d;
    end
  end

  assign y       = y_q;
  assign onehot  = onehot_q;
  assign wrapped = wrapped_q;
  assign dwell   = dwell_q;

endmodule
